// File: rtl/ext_bus_bridge_pkg.sv
// Shared definitions for the external bus bridge: FSM state encoding and default constants.
package ext_bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
  localparam int unsigned TIMEOUT_DEFAULT  = 15;

endpackage

// File: rtl/ext_bus_bridge_if.sv
// CPU-side and external-bus-side signals of the bridge.
// master = the bridge itself, slave = the CPU pipeline plus the external slave it talks to.
interface ext_bus_bridge_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_stall;
  logic        cpu_err;
  logic        bus_stb;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_rdata, bus_ack,
    output cpu_rdata, cpu_ack, cpu_stall, cpu_err,
           bus_stb, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_rdata, bus_ack,
    input  cpu_rdata, cpu_ack, cpu_stall, cpu_err,
           bus_stb, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/ext_bus_bridge_bus_timer.sv
// Wait-cycle counter for the bridge's BUS state; o_tc flags the last allowed wait cycle.
module bus_timer
  import ext_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  // The counter would reach TIMEOUT_CYCLES at this edge: the current cycle is the last one.
  assign o_tc = i_enable && (r_count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ext_bus_bridge.sv
// CPU-to-external-bus bridge: one outstanding access, stalls the pipeline until the slave acks.
// Optional abort of slow accesses is enabled by defining BUS_TIMEOUT_EN.
module ext_bus_bridge
  import ext_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  ext_bus_bridge_if.master bif
);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        w_start;
  logic        w_bus_done;
  logic        w_timeout;

  assign w_start    = (r_state == IDLE) && bif.cpu_req;
  assign w_bus_done = (r_state == BUS) && bif.bus_ack;

`ifdef BUS_TIMEOUT_EN
  logic r_err;

  bus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_start),
    .i_enable ((r_state == BUS) && !bif.bus_ack),
    .o_tc     (w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_bus_done) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign bif.cpu_err = r_err && (r_state == DONE);
`else
  assign w_timeout   = 1'b0;
  assign bif.cpu_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bif.cpu_req) w_state_next = BUS;
      BUS:     if (bif.bus_ack || w_timeout) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_start) begin
        r_we    <= bif.cpu_we;
        r_addr  <= bif.cpu_addr;
        r_wdata <= bif.cpu_wdata;
      end
      // A slave ack always beats a timeout landing on the same cycle.
      if (w_bus_done) begin
        if (!r_we) begin
          r_rdata <= bif.bus_rdata;
        end
      end else if (w_timeout) begin
        r_rdata <= ERR_DATA;
      end
    end
  end

  assign bif.bus_stb   = (r_state == BUS);
  assign bif.bus_we    = r_we;
  assign bif.bus_addr  = r_addr;
  assign bif.bus_wdata = r_wdata;
  assign bif.cpu_rdata = r_rdata;
  assign bif.cpu_ack   = (r_state == DONE);
  assign bif.cpu_stall = w_start || (r_state == BUS);

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Self-checking bench for ext_bus_bridge; run with or without BUS_TIMEOUT_EN defined.
module tb_ext_bus_bridge;

  localparam int T = 4;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;
  logic [31:0] model_rdata = 32'h0;

  ext_bus_bridge_if ifc ();

  ext_bus_bridge #(
    .TIMEOUT_CYCLES(T),
    .ERR_DATA      (32'hDEADBEEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bif (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] slave_rdata;
    int          ack_at;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: an access spends ack_at BUS cycles, or T of them when it times out first.
  task automatic model(input logic we, input int ack_at, input logic [31:0] slave_rdata,
                       output int exp_lat, output logic [31:0] exp_rdata, output logic exp_err);
    bit timed_out;
    int n_bus;
    timed_out = TO_EN && (ack_at == 0 || ack_at > T);
    n_bus     = timed_out ? T : ack_at;
    exp_lat   = 2 + n_bus;
    exp_err   = timed_out;
    if (timed_out) model_rdata = 32'hDEADBEEF;
    else if (!we)  model_rdata = slave_rdata;
    exp_rdata = model_rdata;
  endtask

  task automatic run_access(input vec_t v);
    int          lat = -1;
    int          stall_cnt = 0;
    int          stb_cnt = 0;
    int          bad_bus = 0;
    logic [31:0] got_rdata = 32'h0;
    logic        got_err = 1'b0;
    for (int cyc = 1; cyc <= 60 && lat < 0; cyc++) begin
      @(negedge clk);
      ifc.cpu_req   = (cyc == 1);
      ifc.cpu_we    = (cyc == 1) ? v.we    : 1'($urandom);
      ifc.cpu_addr  = (cyc == 1) ? v.addr  : $urandom;
      ifc.cpu_wdata = (cyc == 1) ? v.wdata : $urandom;
      ifc.bus_ack   = (cyc == 1) || (v.ack_at > 0 && cyc == 1 + v.ack_at);
      ifc.bus_rdata = (v.ack_at > 0 && cyc == 1 + v.ack_at) ? v.slave_rdata : $urandom;
      #1;
      if (ifc.cpu_stall) stall_cnt++;
      if (ifc.bus_stb) begin
        stb_cnt++;
        if (ifc.bus_addr !== v.addr || ifc.bus_wdata !== v.wdata || ifc.bus_we !== v.we) bad_bus++;
      end
      if (ifc.cpu_ack) begin
        lat       = cyc;
        got_rdata = ifc.cpu_rdata;
        got_err   = ifc.cpu_err;
      end
    end
    @(negedge clk);
    ifc.cpu_req = 1'b0;
    ifc.bus_ack = 1'b0;
    #1;
    $display("txn %s we=%0b addr=%08h ack_at=%0d lat=%0d rdata=%08h err=%0b",
             v.name, v.we, v.addr, v.ack_at, lat, got_rdata, got_err);
    check({v.name, ".latency"}, 64'(lat), 64'(v.exp_lat));
    check({v.name, ".stall_cycles"}, 64'(stall_cnt), 64'(v.exp_lat - 1));
    check({v.name, ".stb_cycles"}, 64'(stb_cnt), 64'(v.exp_lat - 2));
    check({v.name, ".bus_stable"}, 64'(bad_bus), 64'd0);
    check({v.name, ".rdata"}, 64'(got_rdata), 64'(v.exp_rdata));
    check({v.name, ".err"}, 64'(got_err), 64'(v.exp_err));
    check({v.name, ".ack_pulse"}, 64'(ifc.cpu_ack), 64'd0);
  endtask

  initial begin
    vec_t        dir[4];
    vec_t        v;
    logic [9:0]  ack_mask;
    logic [9:0]  stb_mask;
    logic [31:0] b2b_rd[2];
    int          n_ack;
    int          ack_seen;

    ifc.cpu_req = 1'b0; ifc.cpu_we = 1'b0; ifc.cpu_addr = '0; ifc.cpu_wdata = '0;
    ifc.bus_ack = 1'b0; ifc.bus_rdata = '0;

    dir[0] = '{"zw_read",   1'b0, 32'h0000_0400, 32'h0,         32'h1234_5678, 1, 3, 32'h1234_5678, 1'b0};
    dir[1] = '{"w3_write",  1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 32'h0,         3, 5, 32'h1234_5678, 1'b0};
    dir[2] = '{"tc_read",   1'b0, 32'h0000_0008, 32'h0,         32'h0BAD_F00D, T, T + 2, 32'h0BAD_F00D, 1'b0};
    dir[3] = '{"w2_write",  1'b1, 32'h0000_2004, 32'h1357_9BDF, 32'h0,         2, 4, 32'h0BAD_F00D, 1'b0};
    // zero-wait: request in cycle 1, ack in cycle 2 counted from the request cycle = latency 3 on this bench's clock count
    dir[0].exp_lat = 2 + 1;

    repeat (2) @(negedge clk);
    #1;
    check("reset.bus_stb", 64'(ifc.bus_stb), 64'd0);
    check("reset.cpu_ack", 64'(ifc.cpu_ack), 64'd0);
    check("reset.cpu_err", 64'(ifc.cpu_err), 64'd0);
    check("reset.cpu_rdata", 64'(ifc.cpu_rdata), 64'd0);
    check("reset.bus_addr_wdata_we", {ifc.bus_addr, ifc.bus_wdata} | 64'(ifc.bus_we), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_access(dir[i]);
    end
    model_rdata = 32'h0BAD_F00D;

    for (int i = 0; i < 16; i++) begin
      v.name        = $sformatf("rand%0d", i);
      v.we          = 1'($urandom_range(0, 1));
      v.addr        = $urandom;
      v.wdata       = $urandom;
      v.slave_rdata = $urandom;
      v.ack_at      = TO_EN ? $urandom_range(1, T + 2) : $urandom_range(1, 8);
      model(v.we, v.ack_at, v.slave_rdata, v.exp_lat, v.exp_rdata, v.exp_err);
      run_access(v);
    end

    if (TO_EN) begin
      v = '{"timeout", 1'b0, 32'h0000_0C00, 32'h0, 32'h0, 0, T + 2, 32'hDEADBEEF, 1'b1};
    end else begin
      v = '{"long_wait", 1'b0, 32'h0000_0C00, 32'h0, 32'h600D_CAFE, 30, 32, 32'h600D_CAFE, 1'b0};
    end
    run_access(v);

    // Reset in the middle of a BUS phase.
    @(negedge clk);
    ifc.cpu_req = 1'b1; ifc.cpu_we = 1'b0; ifc.cpu_addr = 32'h44; ifc.bus_ack = 1'b0;
    @(negedge clk);
    ifc.cpu_req = 1'b0;
    #1;
    check("midrst.stb_before", 64'(ifc.bus_stb), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst.stb_dropped", 64'(ifc.bus_stb), 64'd0);
    check("midrst.stall_dropped", 64'(ifc.cpu_stall), 64'd0);
    check("midrst.rdata_cleared", 64'(ifc.cpu_rdata), 64'd0);
    ack_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      ifc.bus_ack = 1'b1;
      #1;
      if (ifc.cpu_ack) ack_seen++;
    end
    ifc.bus_ack = 1'b0;
    check("midrst.no_ack", 64'(ack_seen), 64'd0);
    v = '{"after_rst", 1'b0, 32'h0000_0048, 32'h0, 32'h7766_5544, 2, 4, 32'h7766_5544, 1'b0};
    run_access(v);

    // Back-to-back: request held high, zero-wait slave acking every cycle.
    ack_mask = '0; stb_mask = '0; n_ack = 0;
    b2b_rd[0] = '0; b2b_rd[1] = '0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      ifc.cpu_req   = (cyc <= 4);
      ifc.cpu_we    = 1'b0;
      ifc.cpu_addr  = 32'h100 + 32'(cyc);
      ifc.bus_ack   = 1'b1;
      ifc.bus_rdata = (cyc == 2) ? 32'hAAAA_0001 : (cyc == 5) ? 32'hBBBB_0002 : $urandom;
      #1;
      ack_mask[cyc-1] = ifc.cpu_ack;
      stb_mask[cyc-1] = ifc.bus_stb;
      if (ifc.cpu_ack && n_ack < 2) begin
        b2b_rd[n_ack] = ifc.cpu_rdata;
        n_ack++;
      end
    end
    ifc.cpu_req = 1'b0;
    ifc.bus_ack = 1'b0;
    $display("txn b2b ack_mask=%010b stb_mask=%010b rd0=%08h rd1=%08h",
             ack_mask, stb_mask, b2b_rd[0], b2b_rd[1]);
    check("b2b.ack_mask", 64'(ack_mask), 64'(10'b00_0010_0100));
    check("b2b.stb_mask", 64'(stb_mask), 64'(10'b00_0001_0010));
    check("b2b.rdata0", 64'(b2b_rd[0]), 64'h0000_0000_AAAA_0001);
    check("b2b.rdata1", 64'(b2b_rd[1]), 64'h0000_0000_BBBB_0002);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
